// File: rtl/hilo_mdu.sv
// hilo_mdu: execute-stage multiply/divide unit that owns the HI/LO registers.
// md ops (mult/multu/div/divu) are accepted when idle. The 64-bit result is
// computed at acceptance into pending registers, and after a fixed Busy
// period it is committed to HI/LO. mthi/mtlo write directly while idle, and
// mfhi/mflo read only the committed registers.
//
// Handshake: Start is high in the single cycle an md op is accepted, which
// requires valid, an md code and Busy low. Busy is high from the next cycle
// for exactly N cycles. Anything presented while Busy is high is dropped.
// Busy is the decoded FSM state (RUN) and serves as the debug view of it.
module hilo_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [3:0]  HILOType,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HILO_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_md;
  logic        is_sdiv;
  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic [31:0] num, den, den_safe, q_mag, r_mag, quo, rem;
  logic [63:0] md_res;

  // Result datapath: both products plus one unsigned divider on magnitudes.
  // Signed divide negates the magnitudes afterwards; 0x80000000 / -1 falls
  // out naturally as 0x80000000 rem 0. A zero divisor is replaced by 1 so
  // the divider stays defined; that result is never committed.
  always_comb begin
    a_sx     = {{32{A[31]}}, A};
    b_sx     = {{32{B[31]}}, B};
    prod_s   = a_sx * b_sx;
    prod_u   = {32'b0, A} * {32'b0, B};
    is_sdiv  = (HILOType == 4'd2);
    num      = (is_sdiv && A[31]) ? -A : A;
    den      = (is_sdiv && B[31]) ? -B : B;
    den_safe = (den == 32'd0) ? 32'd1 : den;
    q_mag    = num / den_safe;
    r_mag    = num % den_safe;
    quo      = (is_sdiv && (A[31] ^ B[31])) ? -q_mag : q_mag;
    rem      = (is_sdiv && A[31]) ? -r_mag : r_mag;
    case (HILOType[1:0])
      2'd0:    md_res = prod_s;
      2'd1:    md_res = prod_u;
      default: md_res = {rem, quo};
    endcase
  end

  assign is_md    = valid && (HILOType[3:2] == 2'b00);
  assign Start    = is_md && (state_q == S_IDLE);
  assign Busy     = (state_q == S_RUN);
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign HILO_out = (HILOType == 4'd4) ? hi_q :
                    (HILOType == 4'd5) ? lo_q : 32'd0;

  // Next-state: accept md ops or mt writes when idle, count down and commit when running.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_RUN;
          count_d = HILOType[1] ? DIV_N : MULT_N;
          phi_d   = md_res[63:32];
          plo_d   = md_res[31:0];
          dz_d    = HILOType[1] && (B == 32'd0);
        end else if (valid && (HILOType == 4'd6)) begin
          hi_d = A;
        end else if (valid && (HILOType == 4'd7)) begin
          lo_d = A;
        end
      end
      S_RUN: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d = S_IDLE;
          if (!dz_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= 4'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      dz_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: doc/hilo_mdu.md
# hilo_mdu

Execute-stage multiply/divide unit that owns the HI/LO registers. It consumes the 4-bit `HILOType` produced by the decoder and carried down the pipeline, together with the forwarded E-stage operands. It runs `mult/multu/div/divu` as fixed-latency multi-cycle operations and services `mthi/mtlo/mfhi/mflo`. Its `Start`/`Busy` outputs feed the hazard unit, which stalls any md/mf/mt instruction in D while the unit is occupied.

## Interface
- `MULT_CYCLES`, default 5: Busy duration for mult/multu, legal range 1..15.
- `DIV_CYCLES`, default 10: Busy duration for div/divu, legal range 1..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `valid`  in  1  the E-stage slot holds a real instruction. 0 for a bubble or flush.
- `HILOType`  in  4  operation code: mult=0, multu=1, div=2, divu=3, mfhi=4, mflo=5, mthi=6, mtlo=7, none=15. Codes 8..14 are treated as none.
- `A`  in  32  forwarded rs value.
- `B`  in  32  forwarded rt value.
- `Start`  out  1  combinational. A md operation is being accepted this cycle.
- `Busy`  out  1  registered. A md operation is in flight.
- `HILO_out`  out  32  combinational read value: HI for mfhi, LO for mflo, 0 otherwise.
- `HI`, `LO`  out  32 each  architectural register values, for debug and trace.

## Operation
- Reset assertion, asynchronous: Busy=0, count=0, HI=LO=0, pending result registers=0, any in-flight operation discarded. `Start` and `HILO_out` then follow their combinational rules (0 when no op).
- Accept rule: `Start = valid & (HILOType<=3) & ~Busy`.
  - At the Start edge, compute the 64-bit result into pending registers `pHI`/`pLO`.
  - Load `count` with MULT_CYCLES or DIV_CYCLES and set Busy=1.
- States:
  - IDLE (Busy=0). On Start, go to RUN.
  - RUN (Busy=1). `count` decrements each edge. The edge at which count==1 commits HI<=pHI, LO<=pLO (except div-by-zero), clears Busy, and returns to IDLE.
- Arithmetic:
  - mult: signed 32x32 to 64 bits, {HI,LO}.
  - multu: unsigned 32x32 to 64 bits, {HI,LO}.
  - div: LO=quotient truncated toward zero, HI=remainder carrying the sign of the dividend A.
  - div special case: A=0x80000000, B=0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient and remainder.
- Divide by zero (B=0, div or divu): the full DIV_CYCLES Busy period still runs, and HI/LO stay unchanged at commit.
- mthi/mtlo: on `valid & ~Busy`, HI<=A or LO<=A at the edge. If Busy=1 the write is ignored; the hazard unit must prevent this, and the bench checks for no effect.
- md op presented while Busy=1: ignored. No restart, no change to pending results, Start=0.
- mfhi/mflo: `HILO_out` reads the committed HI/LO only, never pHI/pLO, regardless of Busy or valid.
- Simultaneous mthi/mtlo and commit cannot occur, because writes require ~Busy.

## Timing
- md op in E during cycle T with Busy=0:
  - Start=1 in T.
  - Busy=1 in cycles T+1..T+N, where N=MULT_CYCLES or DIV_CYCLES.
  - New HI/LO visible from cycle T+N+1, when Busy=0.
- Next md op can be accepted in cycle T+N+1 at the earliest.
- mthi/mtlo in E at cycle T: the new value is visible on HI/LO and `HILO_out` in T+1. So mtlo followed by mflo in consecutive E cycles reads the new value.
- The hazard unit stalls a D-stage md/mf/mt whenever `Start|Busy`. The block itself never stalls anything.
- Reset deasserting mid-cycle: the first Start can occur in the first full cycle after release.

## Test plan
- Reset with ops idle: Busy=0, HI=LO=0, HILO_out=0 with HILOType=4. Assert reset in any cycle and the same values appear immediately, without waiting for an edge.
- mult A=0xFFFFFFFF, B=2: Start for 1 cycle, Busy for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands gives HI=0x00000001, LO=0xFFFFFFFE.
- Divides:
  - div A=0xFFFFFFF9 (-7), B=2: Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7/2: LO=3, HI=1.
  - div A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
  - div by 0 with HI=LO=0x11111111 beforehand: Busy for 10 cycles, HI/LO unchanged.
- mthi A=0x12345678, then mfhi next cycle: HILO_out=0x12345678. Issue mult, then force mtlo A=0xDEADBEEF during Busy: LO ends as the mult result, not 0xDEADBEEF.
- Second mult presented on Busy cycle 2 with different operands: Start=0, original result committed after 5 cycles. Re-present it when Busy=0: accepted, and its result is committed 5 cycles later.
- Assert reset at Busy cycle 3 of a div: Busy=0 and HI=LO=0 immediately. After release, no commit ever appears and HI/LO stay 0.
